// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment driver for the stopwatch BCD time bus.
// Snapshots the time once per scan frame, with leading-zero blanking, pause blink and bad-BCD flag.
module stopwatch_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [16:1] Q,
    input  logic        ON_OFF,
    input  logic        BLANK_LZ,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [4:1]  AN,
    output logic        FRAME,
    output logic        ERR
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pre, pre_n;
    logic [1:0]    idx, idx_n;
    logic [16:1]   snap, snap_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic          tick, frame_start, dark;
    logic [3:0]    nib;
    logic [4:1]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    function automatic logic bad_bcd(input logic [16:1] t);
        bad_bcd = (t[4:1] > 4'd9) || (t[8:5] > 4'd9) || (t[12:9] > 4'd9) || (t[16:13] > 4'd9);
    endfunction

    assign tick        = (pre == PW'(SCAN_DIV - 1));
    assign frame_start = tick && (idx == 2'd3);

    always_comb begin
        pre_n   = tick ? '0 : pre + 1'b1;
        idx_n   = tick ? idx + 2'd1 : idx;
        snap_n  = frame_start ? Q : snap;
        bcnt_n  = bcnt;
        phase_n = phase;
        // Running display always wins over the blink step, even on a frame-start tick
        if (ON_OFF) begin
            bcnt_n  = '0;
            phase_n = 1'b0;
        end else if (frame_start) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + 1'b1;
            end
        end

        case (idx_n)
            2'd0:    nib = snap_n[4:1];
            2'd1:    nib = snap_n[8:5];
            2'd2:    nib = snap_n[12:9];
            default: nib = snap_n[16:13];
        endcase

        dark  = phase_n || ((idx_n == 2'd3) && BLANK_LZ && (nib == 4'd0));
        an_n  = dark ? 4'b1111 : ~(4'b0001 << idx_n);
        seg_n = dark ? 7'b1111111 : seg_decode(nib);
        dp_n  = !(!dark && (idx_n == 2'd2));
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            pre   <= '0;
            idx   <= 2'd3;
            snap  <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
            AN    <= 4'b1111;
            SEG   <= 7'b1111111;
            DP    <= 1'b1;
            FRAME <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            pre   <= pre_n;
            idx   <= idx_n;
            snap  <= snap_n;
            bcnt  <= bcnt_n;
            phase <= phase_n;
            FRAME <= frame_start;
            // Display outputs move only on a digit tick, one cycle after it
            if (tick) begin
                AN  <= an_n;
                SEG <= seg_n;
                DP  <= dp_n;
                ERR <= bad_bcd(snap_n);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized bench for stopwatch_display_scan against a cycle-count based reference model.
// Model derives slot/digit/frame from elapsed cycles and blink phase from the paused-frame count.
module tb_stopwatch_display_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        RESET;
    logic [16:1] Q;
    logic        ON_OFF;
    logic        BLANK_LZ;
    logic [6:0]  SEG;
    logic        DP;
    logic [4:1]  AN;
    logic        FRAME;
    logic        ERR;

    stopwatch_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .RESET(RESET), .Q(Q), .ON_OFF(ON_OFF), .BLANK_LZ(BLANK_LZ),
        .SEG(SEG), .DP(DP), .AN(AN), .FRAME(FRAME), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    // reference model state
    int          m_k;       // edges since reset release
    int          m_paused;  // consecutive paused frame starts
    logic [15:0] m_snap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int slot, digit, ph;
        bit is_tick, fs, dark;
        logic [3:0] nib;
        if (!RESET) begin
            m_k = 0; m_paused = 0; m_snap = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0; e_err = 1'b0;
            return;
        end
        m_k++;
        is_tick = (m_k % SD) == 0;
        slot    = m_k / SD;
        digit   = (slot + 3) % 4;
        fs      = is_tick && (digit == 0);
        if (fs) m_snap = Q;
        if (ON_OFF) m_paused = 0;
        else if (fs) m_paused++;
        ph = ON_OFF ? 0 : (m_paused / BF) % 2;
        e_frame = fs;
        if (is_tick) begin
            nib   = 4'((m_snap >> (4 * digit)) & 16'hF);
            dark  = (ph == 1) || (digit == 3 && BLANK_LZ && nib == 4'd0);
            e_an  = dark ? 4'hF : 4'(~(1 << digit));
            e_seg = dark ? 7'h7F : seg_tab[nib];
            e_dp  = !(!dark && digit == 2);
            e_err = 1'b0;
            for (int i = 0; i < 4; i++)
                if (((m_snap >> (4 * i)) & 16'hF) > 9) e_err = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("AN",    32'(AN),    32'(e_an));
        chk("SEG",   32'(SEG),   32'(e_seg));
        chk("DP",    32'(DP),    32'(e_dp));
        chk("FRAME", 32'(FRAME), 32'(e_frame));
        chk("ERR",   32'(ERR),   32'(e_err));
    endtask

    task automatic drive(input logic r, input logic [15:0] q, input logic on,
                         input logic blz, input int n);
        for (int c = 0; c < n; c++) begin
            RESET = r; Q = q; ON_OFF = on; BLANK_LZ = blz;
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    function automatic logic [15:0] rand_time();
        logic [3:0] mt;
        mt = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
        return {mt, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        logic [15:0] q;
        logic r, on, blz;
        // reset and scan order
        drive(1'b0, 16'h1234, 1'b1, 1'b1, 3);
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 64);
        // mid-frame change: the frame in progress keeps its snapshot
        drive(1'b1, 16'h0959, 1'b1, 1'b1, 6);
        drive(1'b1, 16'h1000, 1'b1, 1'b1, 40);
        // leading-zero blanking on and off
        drive(1'b1, 16'h0305, 1'b1, 1'b1, 48);
        drive(1'b1, 16'h0305, 1'b1, 1'b0, 48);
        // paused blink, then resume
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 160);
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 48);
        // invalid BCD, recovery, reset mid-frame
        drive(1'b1, 16'h1A34, 1'b1, 1'b0, 32);
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 38);
        drive(1'b0, 16'h1234, 1'b1, 1'b0, 1);
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 20);
        // randomized traffic
        q = rand_time(); r = 1'b1; on = 1'b1; blz = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 6) == 0)
                q = ($urandom_range(0, 9) == 0) ? 16'($urandom) : rand_time();
            if ($urandom_range(0, 39) == 0) on = ~on;
            if ($urandom_range(0, 29) == 0) blz = ~blz;
            r = ($urandom_range(0, 399) != 0);
            drive(r, q, on, blz, 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
